// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Constants and FSM encoding shared between the ALU top-level
//                and the sequential binary-to-BCD converter.
//                ALU_WIDTH  - default width of the ALU result (Sal)
//                ALU_DIGITS - default number of BCD digits for display
//                b2b_state_e - converter FSM states (IDLE/SHIFT/DONE)
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int ALU_WIDTH  = 8;
   // 10^ALU_DIGITS must exceed 2^ALU_WIDTH - 1 so every result fits.
   localparam int ALU_DIGITS = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } b2b_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/bcd_adj3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_adj3
//  Description : Double-dabble digit correction. A BCD digit of 5 or more gets
//                3 added so that the following left shift carries correctly
//                into the next decimal digit. Purely combinational.
//  Ports       : digit_i [3:0] - scratch digit before the shift
//                digit_o [3:0] - corrected digit
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_adj3 (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   // A digit >= 5 is at most 9 here, so +3 tops out at 12 and never wraps.
   assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule : bcd_adj3
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential binary-to-BCD converter (shift-add-3), one bit per
//                clock. Sits behind the ALU: Start is the ALU Done level, Bin
//                is the ALU result Sal. Bcd[3:0] drives display6, Bcd[7:4]
//                drives display5, Bcd[11:8] drives the hundreds display.
//  Ports       : Clk      - clock, rising edge
//                Rst_n    - asynchronous active-low reset
//                Start    - request level; a rising edge starts a conversion
//                Bin      - binary value, sampled on the request edge only
//                Sign_in  - sign flag captured together with Bin
//                Busy     - conversion in progress
//                Valid    - one-cycle pulse when Bcd/Sign_out update
//                Bcd      - packed BCD digits, ones in [3:0]
//                Sign_out - sign captured with the current Bcd
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = ALU_WIDTH,
   parameter int DIGITS = ALU_DIGITS
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  Start,
   input  logic [WIDTH-1:0]      Bin,
   input  logic                  Sign_in,
   output logic                  Busy,
   output logic                  Valid,
   output logic [4*DIGITS-1:0]   Bcd,
   output logic                  Sign_out
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);

   b2b_state_e         state_q, state_d;
   logic               start_q;
   logic [WIDTH-1:0]   bin_q, bin_d;
   logic [BCD_W-1:0]   dig_q, dig_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sign_q, sign_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               sign_out_q, sign_out_d;
   logic               valid_q, valid_d;

   logic [BCD_W-1:0]   adj_digits;
   logic               req;

   // Start is a level from the ALU; only its rising edge is a request.
   // start_q tracks Start in every state, so a level held across a whole
   // conversion cannot retrigger once the FSM is back in IDLE.
   assign req = Start & ~start_q;

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_adj
         bcd_adj3 u_adj (
            .digit_i (dig_q[4*i +: 4]),
            .digit_o (adj_digits[4*i +: 4])
         );
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      dig_d      = dig_q;
      cnt_d      = cnt_q;
      sign_d     = sign_q;
      bcd_d      = bcd_q;
      sign_out_d = sign_out_q;
      valid_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               bin_d   = Bin;
               sign_d  = Sign_in;
               dig_d   = '0;
               cnt_d   = CNT_W'(WIDTH);
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // Correct first, then shift digits and remaining binary together.
            {dig_d, bin_d} = {adj_digits, bin_q} << 1;
            cnt_d          = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // Outputs change only here, so partial results are never visible.
            bcd_d      = dig_q;
            sign_out_d = sign_q;
            valid_d    = 1'b1;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= ST_IDLE;
         start_q    <= 1'b0;
         bin_q      <= '0;
         dig_q      <= '0;
         cnt_q      <= '0;
         sign_q     <= 1'b0;
         bcd_q      <= '0;
         sign_out_q <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= Start;
         bin_q      <= bin_d;
         dig_q      <= dig_d;
         cnt_q      <= cnt_d;
         sign_q     <= sign_d;
         bcd_q      <= bcd_d;
         sign_out_q <= sign_out_d;
         valid_q    <= valid_d;
      end
   end

   assign Busy     = (state_q != ST_IDLE);
   assign Valid    = valid_q;
   assign Bcd      = bcd_q;
   assign Sign_out = sign_out_q;

endmodule : bin2bcd_seq
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2bcd_seq
//  Description : Scoreboard bench for bin2bcd_seq. The driver pushes the
//                decimal reference (computed with / and %) plus the cycle on
//                which Valid is due; the monitor pops on every Valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

   localparam int WIDTH   = 8;
   localparam int DIGITS  = 3;
   localparam int BCD_W   = 4 * DIGITS;
   localparam int LAT_CYC = WIDTH + 2;  // from the drive cycle to Valid
   localparam int BUSY_N  = WIDTH + 1;

   logic              Clk;
   logic              Rst_n;
   logic              Start;
   logic [WIDTH-1:0]  Bin;
   logic              Sign_in;
   logic              Busy;
   logic              Valid;
   logic [BCD_W-1:0]  Bcd;
   logic              Sign_out;

   typedef struct {
      logic [BCD_W-1:0] bcd;
      logic             sign;
      int               cyc;
   } exp_t;

   exp_t             sb[$];
   exp_t             e;
   int               checks = 0;
   int               errors = 0;
   int               cyc    = 0;
   logic [BCD_W-1:0] last_bcd  = '0;
   logic             last_sign = 1'b0;
   int               busy_run  = 0;
   logic             busy_prev = 1'b0;
   int               order[256];

   bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .Start    (Start),
      .Bin      (Bin),
      .Sign_in  (Sign_in),
      .Busy     (Busy),
      .Valid    (Valid),
      .Bcd      (Bcd),
      .Sign_out (Sign_out)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(posedge Clk) cyc <= cyc + 1;

   function automatic logic [BCD_W-1:0] ref_bcd(input int v);
      logic [3:0] h, t, o;
      h = 4'(v / 100);
      t = 4'((v / 10) % 10);
      o = 4'(v % 10);
      return {h, t, o};
   endfunction

   // ---------------------------------------------------------------- monitor
   always @(negedge Clk) begin
      if (!Rst_n) begin
         last_bcd  = '0;
         last_sign = 1'b0;
         busy_run  = 0;
         busy_prev = 1'b0;
      end else begin
         if (Valid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid: Bcd=%h Sign_out=%b, required no Valid (cycle %0d)",
                        Bcd, Sign_out, cyc);
            end else begin
               e = sb.pop_front();
               if (Bcd !== e.bcd || Sign_out !== e.sign || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL result: Bcd=%h Sign_out=%b cycle=%0d, required Bcd=%h Sign_out=%b cycle=%0d",
                           Bcd, Sign_out, cyc, e.bcd, e.sign, e.cyc);
               end
            end
            checks++;
            if (Bcd[3:0] > 4'd9 || Bcd[7:4] > 4'd9 || Bcd[11:8] > 4'd9) begin
               errors++;
               $display("FAIL digit_range: Bcd=%h, required every digit <= 9", Bcd);
            end
            last_bcd  = Bcd;
            last_sign = Sign_out;
         end else begin
            checks++;
            if (Bcd !== last_bcd || Sign_out !== last_sign) begin
               errors++;
               $display("FAIL hold: Bcd=%h Sign_out=%b without Valid, required %h %b",
                        Bcd, Sign_out, last_bcd, last_sign);
               last_bcd  = Bcd;
               last_sign = Sign_out;
            end
         end

         if (Busy) begin
            busy_run++;
         end else if (busy_prev) begin
            checks++;
            if (busy_run != BUSY_N || Valid !== 1'b1) begin
               errors++;
               $display("FAIL busy_len: Busy high %0d cycles, Valid at fall=%b, required %0d and 1",
                        busy_run, Valid, BUSY_N);
            end
            busy_run = 0;
         end
         busy_prev = Busy;
      end
   end

   // ----------------------------------------------------------------- driver
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic push_exp(input logic [WIDTH-1:0] b, input logic s);
      exp_t x;
      x.bcd  = ref_bcd(int'(b));
      x.sign = s;
      x.cyc  = cyc + LAT_CYC;
      sb.push_back(x);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results still pending, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic check_idle_outs(input string name);
      checks++;
      if (Busy !== 1'b0 || Valid !== 1'b0 || Bcd !== '0 || Sign_out !== 1'b0) begin
         errors++;
         $display("FAIL %s: Busy=%b Valid=%b Bcd=%h Sign_out=%b, required all 0",
                  name, Busy, Valid, Bcd, Sign_out);
      end
   endtask

   // One request: Bin is scrambled right after capture to show it is sampled once.
   task automatic do_req(input logic [WIDTH-1:0] b, input logic s, input int hold);
      Bin     = b;
      Sign_in = s;
      Start   = 1'b1;
      push_exp(b, s);
      tick();
      Bin     = WIDTH'($urandom);
      Sign_in = 1'($urandom);
      repeat (hold - 1) tick();
      Start = 1'b0;
      wait_drain();
      tick();
   endtask

   initial begin
      Rst_n   = 1'b1;
      Start   = 1'b0;
      Bin     = '0;
      Sign_in = 1'b0;
      #3 Rst_n = 1'b0;
      repeat (3) tick();
      check_idle_outs("reset_state");
      Rst_n = 1'b1;
      repeat (2) tick();

      // Zero, single-cycle Start pulse
      do_req(8'd0, 1'b0, 1);
      // Full scale, negative, Start held a few cycles
      do_req(8'd255, 1'b1, 3);
      // Decimal digit rollover across two separate requests
      do_req(8'd99, 1'b0, 2);
      repeat (3) tick();
      do_req(8'd100, 1'b0, 1);

      // Start held ~30 cycles with a re-rise mid-conversion: exactly one Valid
      Bin     = 8'd42;
      Sign_in = 1'b0;
      Start   = 1'b1;
      push_exp(8'd42, 1'b0);
      tick();
      Bin = 8'd7;
      repeat (3) tick();
      Start = 1'b0;
      tick();
      Start = 1'b1;
      repeat (25) tick();
      Start = 1'b0;
      wait_drain();
      repeat (15) tick();

      // Reset after the 4th shift; Start stays high through reset release,
      // which must count as a fresh request
      Bin     = 8'd200;
      Sign_in = 1'b1;
      Start   = 1'b1;
      tick();
      repeat (4) tick();
      Rst_n = 1'b0;
      #1;
      check_idle_outs("abort_outputs");
      repeat (2) tick();
      check_idle_outs("abort_hold");
      Bin     = 8'd200;
      Sign_in = 1'b0;
      Rst_n   = 1'b1;
      push_exp(8'd200, 1'b0);
      tick();
      Bin = 8'd13;
      repeat (3) tick();
      Start = 1'b0;
      wait_drain();
      tick();

      // Every input value once, in random order, with random sign/hold/gap
      for (int i = 0; i < 256; i++) order[i] = i;
      for (int i = 255; i > 0; i--) begin
         int j, t;
         j        = int'($urandom_range(i, 0));
         t        = order[i];
         order[i] = order[j];
         order[j] = t;
      end
      for (int i = 0; i < 256; i++) begin
         do_req(WIDTH'(order[i]), 1'($urandom), int'($urandom_range(4, 1)));
         repeat ($urandom_range(2, 0)) tick();
      end

      repeat (12) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_bin2bcd_seq
`default_nettype wire
